// File: rtl/vls_sp_arbiter.sv
// Two-lane scratchpad request arbiter: per-lane request FIFOs, round-robin issue onto one port,
// in-order load tracker routing responses back as registered writebacks. Optional: VLS_ARB_BYPASS_EN.
`timescale 1ns/1ps
module vls_sp_arbiter #(
   parameter int DEPTH  = 4,
   parameter int OUTS   = 4,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic                i_clk,
   input  logic                i_nrst,
   input  logic                i_flush,
   input  logic                i_a_valid,
   output logic                o_a_ready,
   input  logic                i_a_we,
   input  logic [6:0]          i_a_op,
   input  logic [ADDR_W-1:0]   i_a_addr,
   input  logic [DATA_W-1:0]   i_a_wdata,
   input  logic [3:0]          i_a_vd,
   input  logic                i_b_valid,
   output logic                o_b_ready,
   input  logic                i_b_we,
   input  logic [6:0]          i_b_op,
   input  logic [ADDR_W-1:0]   i_b_addr,
   input  logic [DATA_W-1:0]   i_b_wdata,
   input  logic [3:0]          i_b_vd,
   output logic                o_sp_req_valid,
   input  logic                i_sp_req_ready,
   output logic                o_sp_req_we,
   output logic [6:0]          o_sp_req_op,
   output logic [ADDR_W-1:0]   o_sp_req_addr,
   output logic [DATA_W-1:0]   o_sp_req_wdata,
   output logic                o_sp_req_lane,
   input  logic                i_sp_rsp_valid,
   input  logic [2*DATA_W-1:0] i_sp_rsp_data,
   output logic                o_wb_valid_a,
   output logic [3:0]          o_wb_vd_a,
   output logic [2*DATA_W-1:0] o_wb_data_a,
   output logic                o_wb_valid_b,
   output logic [3:0]          o_wb_vd_b,
   output logic [2*DATA_W-1:0] o_wb_data_b,
   output logic                o_busy,
   output logic                o_rsp_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(OUTS);
   localparam int EW = 1 + 7 + ADDR_W + DATA_W + 4;

   typedef enum logic {S_RUN = 1'b0, S_DRAIN = 1'b1} state_t;

   state_t              r_state;
   logic                r_alive;
   logic                r_rr_ptr;
   logic                r_hold;
   logic                r_hold_lane;
   logic                r_rsp_err;
   logic                r_wb_valid_a, r_wb_valid_b;
   logic [3:0]          r_wb_vd_a, r_wb_vd_b;
   logic [2*DATA_W-1:0] r_wb_data_a, r_wb_data_b;

   logic                w_in_valid [2];
   logic [EW-1:0]       w_in_ent   [2];
   logic [EW-1:0]       w_head     [2];
   logic                w_empty    [2];
   logic                w_full     [2];
   logic                w_ready    [2];
   logic                w_elig     [2];
   logic                w_push     [2];
   logic                w_byp      [2];

   logic                w_flush_run;
   logic                w_q_valid, w_q_lane;
   logic                w_byp_act, w_byp_lane;
   logic                w_req_valid, w_lane, w_fire;
   logic [EW-1:0]       w_ent;

   logic [4:0]          r_trk_mem [OUTS];
   logic [TW:0]         r_trk_wr, r_trk_rd;
   logic                w_trk_empty, w_trk_full, w_trk_push, w_trk_pop;
   logic [4:0]          w_trk_head;

   assign w_in_valid[0] = i_a_valid;
   assign w_in_valid[1] = i_b_valid;
   assign w_in_ent[0]   = {i_a_we, i_a_op, i_a_addr, i_a_wdata, i_a_vd};
   assign w_in_ent[1]   = {i_b_we, i_b_op, i_b_addr, i_b_wdata, i_b_vd};
   assign w_flush_run   = i_flush && (r_state == S_RUN);

   // Entry layout: {we, op, addr, wdata, vd}; bit EW-1 is the store flag.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_lane
         logic [EW-1:0] r_mem [DEPTH];
         logic [AW:0]   r_wr, r_rd;

         assign w_empty[gi] = (r_wr == r_rd);
         assign w_full[gi]  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
         assign w_head[gi]  = r_mem[r_rd[AW-1:0]];
         assign w_ready[gi] = r_alive && (r_state == S_RUN) && !w_full[gi];
         assign w_elig[gi]  = !w_empty[gi] && (w_head[gi][EW-1] || !w_trk_full);
         assign w_push[gi]  = w_in_valid[gi] && w_ready[gi] && !w_byp[gi];

         always_ff @(posedge i_clk) begin
            if (w_push[gi]) r_mem[r_wr[AW-1:0]] <= w_in_ent[gi];
         end

         always_ff @(posedge i_clk or negedge i_nrst) begin
            if (!i_nrst) begin
               r_wr <= '0;
               r_rd <= '0;
            end else if (w_flush_run) begin
               r_wr <= '0;
               r_rd <= '0;
            end else begin
               if (w_push[gi]) r_wr <= r_wr + (AW+1)'(1);
               if (w_fire && !w_byp_act && (w_lane == 1'(gi))) r_rd <= r_rd + (AW+1)'(1);
            end
         end
      end
   endgenerate

   // A stalled grant is held until it fires so the presented fields never change under backpressure.
   always_comb begin
      w_q_valid = (r_state == S_RUN) && (w_elig[0] || w_elig[1]);
      if (r_hold)
         w_q_lane = r_hold_lane;
      else if (w_elig[0] && w_elig[1])
         w_q_lane = r_rr_ptr;
      else
         w_q_lane = !w_elig[0];
   end

`ifdef VLS_ARB_BYPASS_EN
   logic w_cand [2];
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_byp
         assign w_cand[gi] = w_empty[gi] && !w_elig[1-gi] && w_in_valid[gi] && w_ready[gi]
                             && i_sp_req_ready && (w_in_ent[gi][EW-1] || !w_trk_full);
      end
   endgenerate
   assign w_byp_act  = !w_q_valid && (w_cand[0] || w_cand[1]);
   assign w_byp_lane = (w_cand[0] && w_cand[1]) ? r_rr_ptr : !w_cand[0];
`else
   assign w_byp_act  = 1'b0;
   assign w_byp_lane = 1'b0;
`endif

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_bsel
         assign w_byp[gi] = w_byp_act && (w_byp_lane == 1'(gi));
      end
   endgenerate

   assign w_req_valid = w_q_valid || w_byp_act;
   assign w_lane      = w_byp_act ? w_byp_lane : w_q_lane;
   assign w_ent       = w_byp_act ? w_in_ent[w_byp_lane] : w_head[w_q_lane];
   assign w_fire      = w_req_valid && i_sp_req_ready;

   assign w_trk_empty = (r_trk_wr == r_trk_rd);
   assign w_trk_full  = (r_trk_wr[TW] != r_trk_rd[TW]) && (r_trk_wr[TW-1:0] == r_trk_rd[TW-1:0]);
   assign w_trk_push  = w_fire && !w_ent[EW-1];
   assign w_trk_pop   = i_sp_rsp_valid && !w_trk_empty;
   assign w_trk_head  = r_trk_mem[r_trk_rd[TW-1:0]];

   always_ff @(posedge i_clk) begin
      if (w_trk_push) r_trk_mem[r_trk_wr[TW-1:0]] <= {w_lane, w_ent[3:0]};
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_state      <= S_RUN;
         r_alive      <= 1'b0;
         r_rr_ptr     <= 1'b0;
         r_hold       <= 1'b0;
         r_hold_lane  <= 1'b0;
         r_trk_wr     <= '0;
         r_trk_rd     <= '0;
         r_rsp_err    <= 1'b0;
         r_wb_valid_a <= 1'b0;
         r_wb_vd_a    <= '0;
         r_wb_data_a  <= '0;
         r_wb_valid_b <= 1'b0;
         r_wb_vd_b    <= '0;
         r_wb_data_b  <= '0;
      end else begin
         r_alive     <= 1'b1;
         r_hold      <= w_req_valid && !i_sp_req_ready && !w_flush_run;
         r_hold_lane <= w_lane;
         if (w_fire) r_rr_ptr <= !w_lane;
         if (w_trk_push) r_trk_wr <= r_trk_wr + (TW+1)'(1);
         if (w_trk_pop) r_trk_rd <= r_trk_rd + (TW+1)'(1);
         if (i_sp_rsp_valid && w_trk_empty) r_rsp_err <= 1'b1;

         r_wb_valid_a <= w_trk_pop && !w_trk_head[4];
         r_wb_vd_a    <= (w_trk_pop && !w_trk_head[4]) ? w_trk_head[3:0] : 4'd0;
         r_wb_data_a  <= (w_trk_pop && !w_trk_head[4]) ? i_sp_rsp_data : '0;
         r_wb_valid_b <= w_trk_pop && w_trk_head[4];
         r_wb_vd_b    <= (w_trk_pop && w_trk_head[4]) ? w_trk_head[3:0] : 4'd0;
         r_wb_data_b  <= (w_trk_pop && w_trk_head[4]) ? i_sp_rsp_data : '0;

         case (r_state)
            S_RUN:   if (i_flush) r_state <= S_DRAIN;
            S_DRAIN: if (w_trk_empty) r_state <= S_RUN;
            default: r_state <= S_RUN;
         endcase
      end
   end

   assign o_a_ready      = w_ready[0];
   assign o_b_ready      = w_ready[1];
   assign o_sp_req_valid = w_req_valid;
   assign o_sp_req_lane  = w_req_valid && w_lane;
   assign o_sp_req_we    = w_req_valid && w_ent[EW-1];
   assign o_sp_req_op    = w_req_valid ? w_ent[EW-2 -: 7] : 7'd0;
   assign o_sp_req_addr  = w_req_valid ? w_ent[4+DATA_W +: ADDR_W] : '0;
   assign o_sp_req_wdata = w_req_valid ? w_ent[4 +: DATA_W] : '0;
   assign o_wb_valid_a   = r_wb_valid_a;
   assign o_wb_vd_a      = r_wb_vd_a;
   assign o_wb_data_a    = r_wb_data_a;
   assign o_wb_valid_b   = r_wb_valid_b;
   assign o_wb_vd_b      = r_wb_vd_b;
   assign o_wb_data_b    = r_wb_data_b;
   assign o_busy         = !w_empty[0] || !w_empty[1] || !w_trk_empty;
   assign o_rsp_err      = r_rsp_err;
endmodule

// File: tb/tb_vls_sp_arbiter.sv
// Self-checking bench for vls_sp_arbiter: queue-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with a mid-run async reset.
`timescale 1ns/1ps
module tb_vls_sp_arbiter;
   localparam int DEPTH = 4, OUTS = 4, ADDR_W = 16, DATA_W = 16;

   typedef struct packed {
      logic              we;
      logic [6:0]        op;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [3:0]        vd;
   } req_t;
   typedef struct packed {
      logic       lane;
      logic [3:0] vd;
   } tag_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0, flush = 1'b0;
   logic a_valid = 0, a_we = 0, b_valid = 0, b_we = 0;
   logic [6:0] a_op = '0, b_op = '0;
   logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
   logic [DATA_W-1:0] a_wdata = '0, b_wdata = '0;
   logic [3:0] a_vd = '0, b_vd = '0;
   logic sp_req_ready = 0, sp_rsp_valid = 0;
   logic [2*DATA_W-1:0] sp_rsp_data = '0;
   logic a_ready, b_ready, sp_req_valid, sp_req_we, sp_req_lane;
   logic [6:0] sp_req_op;
   logic [ADDR_W-1:0] sp_req_addr;
   logic [DATA_W-1:0] sp_req_wdata;
   logic wb_valid_a, wb_valid_b, busy, rsp_err;
   logic [3:0] wb_vd_a, wb_vd_b;
   logic [2*DATA_W-1:0] wb_data_a, wb_data_b;

   vls_sp_arbiter #(.DEPTH(DEPTH), .OUTS(OUTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .i_clk(clk), .i_nrst(rst_n), .i_flush(flush),
      .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_we(a_we), .i_a_op(a_op),
      .i_a_addr(a_addr), .i_a_wdata(a_wdata), .i_a_vd(a_vd),
      .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_we(b_we), .i_b_op(b_op),
      .i_b_addr(b_addr), .i_b_wdata(b_wdata), .i_b_vd(b_vd),
      .o_sp_req_valid(sp_req_valid), .i_sp_req_ready(sp_req_ready), .o_sp_req_we(sp_req_we),
      .o_sp_req_op(sp_req_op), .o_sp_req_addr(sp_req_addr), .o_sp_req_wdata(sp_req_wdata),
      .o_sp_req_lane(sp_req_lane), .i_sp_rsp_valid(sp_rsp_valid), .i_sp_rsp_data(sp_rsp_data),
      .o_wb_valid_a(wb_valid_a), .o_wb_vd_a(wb_vd_a), .o_wb_data_a(wb_data_a),
      .o_wb_valid_b(wb_valid_b), .o_wb_vd_b(wb_vd_b), .o_wb_data_b(wb_data_b),
      .o_busy(busy), .o_rsp_err(rsp_err)
   );

   int n_checks = 0;
   int n_fail = 0;

   function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // Reference model state: lane queues, outstanding-load queue, mode flags.
   req_t qa[$], qb[$];
   tag_t trk[$];
   logic [1:0] fire_log[$];
   bit m_run = 1, m_alive = 0, m_last = 1, m_hold = 0, m_hold_lane = 0, m_err = 0;
   bit m_wb_va = 0, m_wb_vb = 0;
   logic [3:0] m_vd_a = '0, m_vd_b = '0;
   logic [2*DATA_W-1:0] m_data_a = '0, m_data_b = '0;
   bit ea, eb, e_a_ready, e_b_ready, e_valid, e_lane, e_busy;
   req_t e_req;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("reset_outputs", 128'({a_ready, b_ready, sp_req_valid, sp_req_we, sp_req_op, sp_req_addr,
             sp_req_wdata, sp_req_lane, wb_valid_a, wb_vd_a, wb_data_a, wb_valid_b, wb_vd_b,
             wb_data_b, busy, rsp_err}), 128'(0));
      end else begin
         ea = (qa.size() > 0) && (qa[0].we || trk.size() < OUTS);
         eb = (qb.size() > 0) && (qb[0].we || trk.size() < OUTS);
         e_a_ready = m_alive && m_run && (qa.size() < DEPTH);
         e_b_ready = m_alive && m_run && (qb.size() < DEPTH);
         e_valid = m_run && (ea || eb);
         if (m_hold) e_lane = m_hold_lane;
         else if (ea && eb) e_lane = !m_last;
         else e_lane = !ea;
         e_req = '0;
         if (e_valid) e_req = e_lane ? qb[0] : qa[0];
         e_busy = (qa.size() > 0) || (qb.size() > 0) || (trk.size() > 0);
         chk("a_ready", 128'(a_ready), 128'(e_a_ready));
         chk("b_ready", 128'(b_ready), 128'(e_b_ready));
         chk("sp_req_valid", 128'(sp_req_valid), 128'(e_valid));
         if (e_valid) begin
            chk("sp_req_lane", 128'(sp_req_lane), 128'(e_lane));
            chk("sp_req_fields", 128'({sp_req_we, sp_req_op, sp_req_addr, sp_req_wdata}),
                128'({e_req.we, e_req.op, e_req.addr, e_req.wdata}));
         end
         chk("wb_a", 128'({wb_valid_a, wb_vd_a, wb_data_a}), 128'({m_wb_va, m_vd_a, m_data_a}));
         chk("wb_b", 128'({wb_valid_b, wb_vd_b, wb_data_b}), 128'({m_wb_vb, m_vd_b, m_data_b}));
         chk("busy", 128'(busy), 128'(e_busy));
         chk("rsp_err", 128'(rsp_err), 128'(m_err));
      end
   end

   always @(posedge clk) begin
      req_t r;
      tag_t t;
      bit fire, trk_was_empty;
      if (!rst_n) begin
         qa.delete(); qb.delete(); trk.delete();
         m_run = 1; m_alive = 0; m_last = 1; m_hold = 0; m_hold_lane = 0; m_err = 0;
         m_wb_va = 0; m_wb_vb = 0; m_vd_a = '0; m_vd_b = '0; m_data_a = '0; m_data_b = '0;
      end else begin
         trk_was_empty = (trk.size() == 0);
         fire = e_valid && sp_req_ready;
         m_wb_va = 0; m_wb_vb = 0; m_vd_a = '0; m_vd_b = '0; m_data_a = '0; m_data_b = '0;
         if (sp_rsp_valid) begin
            if (trk.size() > 0) begin
               t = trk.pop_front();
               if (t.lane) begin m_wb_vb = 1; m_vd_b = t.vd; m_data_b = sp_rsp_data; end
               else begin m_wb_va = 1; m_vd_a = t.vd; m_data_a = sp_rsp_data; end
            end else m_err = 1;
         end
         if (fire) begin
            if (e_lane) r = qb.pop_front();
            else r = qa.pop_front();
            if (!r.we) begin t.lane = e_lane; t.vd = r.vd; trk.push_back(t); end
            m_last = e_lane;
            fire_log.push_back({e_lane, r.we});
         end
         m_hold = e_valid && !sp_req_ready && !(flush && m_run);
         m_hold_lane = e_lane;
         if (m_run && flush) begin
            qa.delete(); qb.delete(); m_run = 0;
         end else begin
            if (a_valid && e_a_ready) qa.push_back({a_we, a_op, a_addr, a_wdata, a_vd});
            if (b_valid && e_b_ready) qb.push_back({b_we, b_op, b_addr, b_wdata, b_vd});
            if (!m_run && trk_was_empty) m_run = 1;
         end
         m_alive = 1;
      end
   end

   bit auto_rsp = 0;

   task automatic step();
      @(posedge clk);
      #1;
      if (auto_rsp) begin
         sp_rsp_valid = (trk.size() > 0);
         sp_rsp_data = $urandom;
      end
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (busy && n < 300) begin step(); n++; end
      chk(nm, 128'(busy), 128'(0));
   endtask

   task automatic idle_in();
      a_valid = 0; b_valid = 0; flush = 0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      step();
      chk("ready_after_reset", 128'({a_ready, b_ready}), 128'(2'b11));

      // Round-robin: three loads on each lane at once.
      sp_req_ready = 1; auto_rsp = 1; fire_log.delete();
      for (int i = 0; i < 3; i++) begin
         a_valid = 1; a_we = 0; a_vd = 4'(i); a_addr = 16'(i);
         b_valid = 1; b_we = 0; b_vd = 4'(8 + i); b_addr = 16'(16 + i);
         step();
      end
      idle_in();
      wait_idle("rr_drain");
      chk("rr_count", 128'(fire_log.size()), 128'(6));
      for (int i = 0; i < 6; i++)
         if (i < fire_log.size()) chk("rr_seq", 128'(fire_log[i]), 128'({i[0], 1'b0}));

      // Backpressure: five stores into lane A with the port stalled.
      sp_req_ready = 0; fire_log.delete();
      for (int i = 0; i < 5; i++) begin
         a_valid = 1; a_we = 1; a_addr = 16'h100 + 16'(i); a_wdata = 16'(i); a_op = 7'h11;
         step();
         if (i == 3) chk("bp_full_ready", 128'(a_ready), 128'(0));
      end
      idle_in();
      for (int i = 0; i < 3; i++) begin
         chk("bp_stable_addr", 128'({sp_req_valid, sp_req_addr, sp_req_op}), 128'({1'b1, 16'h100, 7'h11}));
         step();
      end
      sp_req_ready = 1;
      wait_idle("bp_drain");
      chk("bp_count", 128'(fire_log.size()), 128'(4));

      // Tracker full: five loads on A without responses, then a store on B.
      auto_rsp = 0; sp_rsp_valid = 0; fire_log.delete();
      for (int i = 0; i < 5; i++) begin
         a_valid = 1; a_we = 0; a_vd = 4'(i);
         step();
      end
      idle_in();
      b_valid = 1; b_we = 1; b_addr = 16'h200;
      step();
      idle_in();
      repeat (4) step();
      chk("tf_count", 128'(fire_log.size()), 128'(5));
      for (int i = 0; i < 4; i++)
         if (i < fire_log.size()) chk("tf_loads", 128'(fire_log[i]), 128'(2'b00));
      if (fire_log.size() > 4) chk("tf_store_b", 128'(fire_log[4]), 128'(2'b11));
      chk("tf_stalled", 128'({sp_req_valid, busy}), 128'(2'b01));
      auto_rsp = 1;
      wait_idle("tf_drain");

      // Response routing.
      auto_rsp = 0; sp_rsp_valid = 0;
      a_valid = 1; a_we = 0; a_vd = 4'd3; a_addr = 16'h30;
      step();
      idle_in();
      b_valid = 1; b_we = 0; b_vd = 4'd7; b_addr = 16'h70;
      step();
      idle_in();
      step(); step();
      sp_rsp_valid = 1; sp_rsp_data = 32'hDEAD_BEEF;
      step();
      chk("route_a", 128'({wb_valid_a, wb_vd_a, wb_data_a, wb_valid_b}), 128'({1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0}));
      sp_rsp_data = 32'h1234_5678;
      step();
      chk("route_b", 128'({wb_valid_b, wb_vd_b, wb_data_b, wb_valid_a}), 128'({1'b1, 4'd7, 32'h1234_5678, 1'b0}));
      sp_rsp_valid = 0;
      step();
      chk("route_pulse", 128'(wb_valid_b), 128'(0));

      // Flush: two outstanding loads on A, two stores queued on B.
      sp_req_ready = 1;
      a_valid = 1; a_we = 0; a_vd = 4'd1;
      step(); step();
      idle_in();
      step(); step();
      sp_req_ready = 0;
      b_valid = 1; b_we = 1; b_addr = 16'h400;
      step(); step();
      idle_in();
      flush = 1;
      step();
      flush = 0;
      chk("flush_drain", 128'({a_ready, b_ready, sp_req_valid, busy}), 128'(4'b0001));
      sp_req_ready = 1; fire_log.delete();
      step(); step();
      chk("flush_no_issue", 128'(fire_log.size()), 128'(0));
      sp_rsp_valid = 1; sp_rsp_data = 32'hA1;
      step();
      chk("flush_rsp1", 128'({wb_valid_a, wb_data_a}), 128'({1'b1, 32'hA1}));
      sp_rsp_data = 32'hA2;
      step();
      chk("flush_rsp2", 128'({wb_valid_a, wb_data_a}), 128'({1'b1, 32'hA2}));
      sp_rsp_valid = 0;
      step();
      chk("flush_run_again", 128'({a_ready, rsp_err}), 128'(2'b10));
      sp_rsp_valid = 1; sp_rsp_data = 32'hBAD;
      step();
      sp_rsp_valid = 0;
      chk("flush_extra_err", 128'({rsp_err, wb_valid_a, wb_valid_b}), 128'(3'b100));

      // Randomized traffic with an asynchronous reset in the middle.
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) begin
            @(posedge clk);
            #3 rst_n = 0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1;
            idle_in(); sp_rsp_valid = 0;
            chk("rand_reset_busy", 128'(busy), 128'(0));
            step();
            chk("rand_reset_ready", 128'({a_ready, b_ready}), 128'(2'b11));
         end
         a_valid = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1));
         a_op = 7'($urandom); a_addr = 16'($urandom); a_wdata = 16'($urandom); a_vd = 4'($urandom);
         b_valid = 1'($urandom_range(0, 1)); b_we = 1'($urandom_range(0, 1));
         b_op = 7'($urandom); b_addr = 16'($urandom); b_wdata = 16'($urandom); b_vd = 4'($urandom);
         sp_req_ready = ($urandom_range(0, 9) < 7);
         flush = ($urandom_range(0, 79) == 0);
         if (trk.size() > 0) sp_rsp_valid = ($urandom_range(0, 9) < 4);
         else sp_rsp_valid = (i > 700) && ($urandom_range(0, 49) == 0);
         sp_rsp_data = $urandom;
         step();
      end
      idle_in();
      sp_rsp_valid = 0; sp_req_ready = 1; auto_rsp = 1;
      wait_idle("final_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
